// File: rtl/dpram_be_clr.sv
// Single-clock true dual-port RAM with byte enables, 1- or 2-cycle read latency,
// selectable read-during-write result and a sweep that fills the array after reset or on request.
module dpram_be_clr #(
   parameter int         data_width_g  = 8,
   parameter int         addr_width_g  = 14,
   parameter int         rd_latency_g  = 1,
   parameter int         rdw_new_g     = 0,
   parameter logic [7:0] clear_value_g = 8'h00
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      clear_req,
   output logic                      busy,
   input  logic                      cs_a,
   input  logic                      wren_a,
   input  logic [data_width_g/8-1:0] be_a,
   input  logic [addr_width_g-1:0]   address_a,
   input  logic [data_width_g-1:0]   data_a,
   output logic [data_width_g-1:0]   q_a,
   output logic                      valid_a,
   input  logic                      cs_b,
   input  logic                      wren_b,
   input  logic [data_width_g/8-1:0] be_b,
   input  logic [addr_width_g-1:0]   address_b,
   input  logic [data_width_g-1:0]   data_b,
   output logic [data_width_g-1:0]   q_b,
   output logic                      valid_b
);

   // state    | meaning
   // ST_CLEAR | sweeping clear_value_g through every word, ports ignored
   // ST_IDLE  | normal dual-port operation

   localparam int NB    = data_width_g / 8;
   localparam int DEPTH = 1 << addr_width_g;
   localparam logic [addr_width_g-1:0] ADDR_ONE = {{(addr_width_g-1){1'b0}}, 1'b1};

   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

   state_t                    state_q;
   logic [addr_width_g-1:0]   clr_addr_q;
   logic                      busy_q;
   logic [data_width_g-1:0]   mem [DEPTH];

   logic                      acc_a, acc_b, wr_a, wr_b;
   logic [data_width_g-1:0]   old_a, old_b, new_a, new_b, rd_a, rd_b;
   logic [data_width_g-1:0]   q1_a_q, q1_b_q;
   logic                      v1_a_q, v1_b_q;

   assign acc_a = cs_a && (state_q == ST_IDLE);
   assign acc_b = cs_b && (state_q == ST_IDLE);
   assign wr_a  = acc_a && wren_a;
   assign wr_b  = acc_b && wren_b;
   assign old_a = mem[address_a];
   assign old_b = mem[address_b];

   // Fully merged word seen at each port's address: B lanes first, A lanes override.
   always_comb begin
      new_a = old_a;
      new_b = old_b;
      for (int i = 0; i < NB; i++) begin
         if (wr_b && be_b[i] && (address_b == address_a)) new_a[i*8 +: 8] = data_b[i*8 +: 8];
         if (wr_a && be_a[i])                             new_a[i*8 +: 8] = data_a[i*8 +: 8];
         if (wr_b && be_b[i])                             new_b[i*8 +: 8] = data_b[i*8 +: 8];
         if (wr_a && be_a[i] && (address_a == address_b)) new_b[i*8 +: 8] = data_a[i*8 +: 8];
      end
   end

   assign rd_a = (rdw_new_g != 0) ? new_a : old_a;
   assign rd_b = (rdw_new_g != 0) ? new_b : old_b;

   // When both ports write one address, new_a and new_b are the same merged word.
   always_ff @(posedge clock) begin
      if (state_q == ST_CLEAR) begin
         mem[clr_addr_q] <= {NB{clear_value_g}};
      end else begin
         if (wr_a) mem[address_a] <= new_a;
         if (wr_b) mem[address_b] <= new_b;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
         busy_q     <= 1'b1;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               clr_addr_q <= clr_addr_q + ADDR_ONE;
               if (clr_addr_q == '1) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ST_IDLE: begin
               if (clear_req) begin
                  state_q    <= ST_CLEAR;
                  clr_addr_q <= '0;
                  busy_q     <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_CLEAR;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   assign busy = busy_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         q1_a_q <= '0;
         q1_b_q <= '0;
         v1_a_q <= 1'b0;
         v1_b_q <= 1'b0;
      end else begin
         v1_a_q <= acc_a;
         v1_b_q <= acc_b;
         if (acc_a) q1_a_q <= rd_a;
         if (acc_b) q1_b_q <= rd_b;
      end
   end

   if (rd_latency_g == 2) begin : g_lat2
      logic [data_width_g-1:0] q2_a_q, q2_b_q;
      logic                    v2_a_q, v2_b_q;

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            q2_a_q <= '0;
            q2_b_q <= '0;
            v2_a_q <= 1'b0;
            v2_b_q <= 1'b0;
         end else begin
            v2_a_q <= v1_a_q;
            v2_b_q <= v1_b_q;
            if (v1_a_q) q2_a_q <= q1_a_q;
            if (v1_b_q) q2_b_q <= q1_b_q;
         end
      end

      assign q_a     = q2_a_q;
      assign q_b     = q2_b_q;
      assign valid_a = v2_a_q;
      assign valid_b = v2_b_q;
   end else begin : g_lat1
      assign q_a     = q1_a_q;
      assign q_b     = q1_b_q;
      assign valid_a = v1_a_q;
      assign valid_b = v1_b_q;
   end

endmodule

// File: tb/tb_dpram_be_clr.sv
// Directed bench: dut0 is 16-bit/depth 16/latency 1/old-data/fill A5,
// dut1 is 16-bit/depth 16/latency 2/new-data/fill 00; both see the same stimulus.
module tb_dpram_be_clr;

   logic        clock = 1'b0;
   logic        reset_n, clear_req;
   logic        cs_a, wren_a, cs_b, wren_b;
   logic [1:0]  be_a, be_b;
   logic [3:0]  address_a, address_b;
   logic [15:0] data_a, data_b;
   logic [15:0] q_a0, q_b0, q_a1, q_b1;
   logic        valid_a0, valid_b0, valid_a1, valid_b1, busy0, busy1;

   int n_checks = 0;
   int n_errors = 0;
   int leak     = 0;
   int n;

   always #5 clock = ~clock;

   dpram_be_clr #(.data_width_g(16), .addr_width_g(4), .rd_latency_g(1),
                  .rdw_new_g(0), .clear_value_g(8'hA5)) u_dut0 (
      .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .busy(busy0),
      .cs_a(cs_a), .wren_a(wren_a), .be_a(be_a), .address_a(address_a),
      .data_a(data_a), .q_a(q_a0), .valid_a(valid_a0),
      .cs_b(cs_b), .wren_b(wren_b), .be_b(be_b), .address_b(address_b),
      .data_b(data_b), .q_b(q_b0), .valid_b(valid_b0));

   dpram_be_clr #(.data_width_g(16), .addr_width_g(4), .rd_latency_g(2),
                  .rdw_new_g(1), .clear_value_g(8'h00)) u_dut1 (
      .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .busy(busy1),
      .cs_a(cs_a), .wren_a(wren_a), .be_a(be_a), .address_a(address_a),
      .data_a(data_a), .q_a(q_a1), .valid_a(valid_a1),
      .cs_b(cs_b), .wren_b(wren_b), .be_b(be_b), .address_b(address_b),
      .data_b(data_b), .q_b(q_b1), .valid_b(valid_b1));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_ports();
      cs_a = 1'b0; wren_a = 1'b0; be_a = 2'b00;
      cs_b = 1'b0; wren_b = 1'b0; be_b = 2'b00;
   endtask

   task automatic drv_a(input logic wr, input logic [1:0] be, input logic [3:0] ad, input logic [15:0] d);
      cs_a = 1'b1; wren_a = wr; be_a = be; address_a = ad; data_a = d;
   endtask

   task automatic drv_b(input logic wr, input logic [1:0] be, input logic [3:0] ad, input logic [15:0] d);
      cs_b = 1'b1; wren_b = wr; be_b = be; address_b = ad; data_b = d;
   endtask

   // One access cycle, then one idle cycle so the latency-2 instance can be checked.
   task automatic run_op(input string tag, input logic use_a, input logic use_b,
                         input logic [15:0] ea0, input logic [15:0] eb0,
                         input logic [15:0] ea1, input logic [15:0] eb1);
      step();
      if (use_a) begin chk({tag, "_qa0"}, q_a0, ea0); chk({tag, "_va0"}, valid_a0, 1); end
      if (use_b) begin chk({tag, "_qb0"}, q_b0, eb0); chk({tag, "_vb0"}, valid_b0, 1); end
      idle_ports();
      step();
      if (use_a) begin chk({tag, "_qa1"}, q_a1, ea1); chk({tag, "_va1"}, valid_a1, 1); end
      if (use_b) begin chk({tag, "_qb1"}, q_b1, eb1); chk({tag, "_vb1"}, valid_b1, 1); end
      chk({tag, "_va0_off"}, valid_a0, 0);
   endtask

   // Counts edges until busy drops; accepted accesses must not produce valid pulses meanwhile.
   task automatic wait_clear(output int cnt);
      cnt  = 0;
      leak = 0;
      while (cnt < 100) begin
         step();
         cnt++;
         if (valid_a0 || valid_b0) leak++;
         if (cnt > 1 && (valid_a1 || valid_b1)) leak++;
         if (!busy0) break;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; clear_req = 1'b0; idle_ports();
      address_a = '0; address_b = '0; data_a = '0; data_b = '0;
      step(); step();
      chk("rst_busy0", busy0, 1);
      chk("rst_busy1", busy1, 1);
      chk("rst_va0", valid_a0, 0);
      chk("rst_qa0", q_a0, 0);
      chk("rst_qa1", q_a1, 0);

      reset_n = 1'b1;
      wait_clear(n);
      chk("sweep_len", n, 16);
      chk("sweep_leak", leak, 0);
      chk("sweep_busy1", busy1, 0);

      for (int i = 0; i < 16; i++) begin
         drv_a(1'b0, 2'b00, 4'(i), 16'h0);
         step();
         chk("rdclr_va0", valid_a0, 1);
         chk("rdclr_qa0", q_a0, 16'hA5A5);
         if (i > 0) begin
            chk("rdclr_va1", valid_a1, 1);
            chk("rdclr_qa1", q_a1, 16'h0000);
         end else begin
            chk("rdclr_lat2_first", valid_a1, 0);
         end
      end
      idle_ports();
      step();
      chk("rdclr_end_va0", valid_a0, 0);
      chk("rdclr_end_va1", valid_a1, 1);

      drv_a(1'b1, 2'b11, 4'd3, 16'hFFFF);
      run_op("w3_ffff", 1, 0, 16'hA5A5, 16'h0, 16'hFFFF, 16'h0);
      drv_a(1'b1, 2'b01, 4'd3, 16'h1234);
      run_op("w3_be01", 1, 0, 16'hFFFF, 16'h0, 16'hFF34, 16'h0);
      drv_a(1'b0, 2'b00, 4'd3, 16'h0);
      run_op("rd3", 1, 0, 16'hFF34, 16'h0, 16'hFF34, 16'h0);

      drv_a(1'b1, 2'b11, 4'd5, 16'h1111);
      drv_b(1'b1, 2'b11, 4'd5, 16'h2222);
      run_op("ww_full", 1, 1, 16'hA5A5, 16'hA5A5, 16'h1111, 16'h1111);
      drv_a(1'b0, 2'b00, 4'd5, 16'h0);
      run_op("rd5", 1, 0, 16'h1111, 16'h0, 16'h1111, 16'h0);

      drv_a(1'b1, 2'b10, 4'd6, 16'hAAAA);
      drv_b(1'b1, 2'b11, 4'd6, 16'hBBBB);
      run_op("ww_lane", 1, 1, 16'hA5A5, 16'hA5A5, 16'hAABB, 16'hAABB);
      drv_b(1'b0, 2'b00, 4'd6, 16'h0);
      run_op("rd6", 0, 1, 16'h0, 16'hAABB, 16'h0, 16'hAABB);

      drv_a(1'b1, 2'b11, 4'd2, 16'h0077);
      drv_b(1'b0, 2'b00, 4'd2, 16'h0);
      run_op("xrdw", 1, 1, 16'hA5A5, 16'hA5A5, 16'h0077, 16'h0077);
      drv_b(1'b0, 2'b00, 4'd2, 16'h0);
      run_op("rd2", 0, 1, 16'h0, 16'h0077, 16'h0, 16'h0077);

      drv_a(1'b0, 2'b00, 4'd3, 16'h0);
      step();
      chk("pipe_c0_qa0", q_a0, 16'hFF34);
      chk("pipe_c0_va1", valid_a1, 0);
      drv_a(1'b0, 2'b00, 4'd5, 16'h0);
      step();
      chk("pipe_c1_qa0", q_a0, 16'h1111);
      chk("pipe_c1_va1", valid_a1, 1);
      chk("pipe_c1_qa1", q_a1, 16'hFF34);
      drv_a(1'b0, 2'b00, 4'd6, 16'h0);
      step();
      chk("pipe_c2_qa0", q_a0, 16'hAABB);
      chk("pipe_c2_qa1", q_a1, 16'h1111);
      idle_ports();
      step();
      chk("pipe_c3_va0", valid_a0, 0);
      chk("pipe_c3_hold_qa0", q_a0, 16'hAABB);
      chk("pipe_c3_va1", valid_a1, 1);
      chk("pipe_c3_qa1", q_a1, 16'hAABB);
      step();
      chk("pipe_c4_va1", valid_a1, 0);
      chk("pipe_c4_hold_qa1", q_a1, 16'hAABB);

      clear_req = 1'b1;
      drv_a(1'b1, 2'b11, 4'd9, 16'h5555);
      step();
      chk("creq_busy0", busy0, 1);
      chk("creq_va0", valid_a0, 1);
      chk("creq_qa0", q_a0, 16'hA5A5);
      drv_a(1'b1, 2'b11, 4'd0, 16'hDEAD);
      wait_clear(n);
      clear_req = 1'b0;
      idle_ports();
      chk("creq_len", n, 16);
      chk("creq_leak", leak, 0);
      chk("creq_hold_qa0", q_a0, 16'hA5A5);
      chk("creq_hold_qa1", q_a1, 16'h5555);
      chk("creq_busy1", busy1, 0);
      drv_a(1'b0, 2'b00, 4'd0, 16'h0);
      run_op("rd0_after_clr", 1, 0, 16'hA5A5, 16'h0, 16'h0000, 16'h0);
      drv_a(1'b0, 2'b00, 4'd9, 16'h0);
      run_op("rd9_after_clr", 1, 0, 16'hA5A5, 16'h0, 16'h0000, 16'h0);

      drv_a(1'b1, 2'b11, 4'd4, 16'h4321);
      run_op("w4", 1, 0, 16'hA5A5, 16'h0, 16'h4321, 16'h0);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      repeat (7) step();
      chk("mid_busy0", busy0, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("mid_rst_qa0", q_a0, 0);
      chk("mid_rst_qa1", q_a1, 0);
      chk("mid_rst_va0", valid_a0, 0);
      chk("mid_rst_busy1", busy1, 1);
      step();
      reset_n = 1'b1;
      wait_clear(n);
      chk("restart_len", n, 16);
      drv_a(1'b0, 2'b00, 4'd4, 16'h0);
      run_op("rd4_after_rst", 1, 0, 16'hA5A5, 16'h0, 16'h0000, 16'h0);
      drv_b(1'b0, 2'b00, 4'd15, 16'h0);
      run_op("rd15_after_rst", 0, 1, 16'h0, 16'hA5A5, 16'h0, 16'h0000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
